if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC generator.
- Issues one instruction-memory request per PC over a valid/ready request channel and accepts the data on a valid-only response channel.
- Loads the IF/ID pipeline register with {pc, instr, valid}.
- Drives fetch_busy back as the PC-stall source, so the PC advances exactly once per completed fetch. Flush (taken branch/jump) and ID-stall come from the hazard unit.

---
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_fetch_unit.sv | 72 +++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request (valid/ready) and response (valid-only) channels
interface if_fetch_unit_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding IF stage loading IF/ID, optional misalign trap via IF_MISALIGN_TRAP_EN
module if_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  input  logic            if_stall,
  input  logic            if_flush,
  if_fetch_unit_if.master imem,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            if_id_misalign,
`endif
  output logic            fetch_busy
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] req_pc, buf_pc, buf_instr;
  logic mis, hs, ld_rsp, ld_hold, ld_mis;
`ifdef IF_MISALIGN_TRAP_EN
  assign mis = |pc_i[1:0];
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    imem.req_valid = state == REQ && !if_flush && !mis;
    imem.req_addr  = {pc_i[XLEN-1:2], 2'b00};
    hs             = imem.req_valid && imem.req_ready;
    ld_rsp         = state == WAIT && imem.rsp_valid && !if_stall && !if_flush;
    ld_hold        = state == HOLD && !if_stall && !if_flush;
    ld_mis         = state == REQ && !if_flush && mis;
    fetch_busy     = !(ld_rsp || ld_hold || ld_mis || if_flush);
    state_n        = state;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = hs ? WAIT : REQ;
      WAIT:    state_n = !imem.rsp_valid ? (if_flush ? DROP : WAIT) : (if_flush || !if_stall) ? REQ : HOLD;
      HOLD:    state_n = (if_flush || !if_stall) ? REQ : HOLD;
      DROP:    state_n = imem.rsp_valid ? REQ : DROP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_pc      <= '0;
      buf_pc      <= '0;
      buf_instr   <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) req_pc <= pc_i;
      if (state == WAIT && imem.rsp_valid && if_stall && !if_flush) {buf_pc, buf_instr} <= {req_pc, imem.rsp_data};
      if (if_flush) {if_id_pc, if_id_instr, if_id_valid} <= {{XLEN{1'b0}}, NOP_INSTR, 1'b0};
      else if (ld_rsp) {if_id_pc, if_id_instr, if_id_valid} <= {req_pc, imem.rsp_data, 1'b1};
      else if (ld_hold) {if_id_pc, if_id_instr, if_id_valid} <= {buf_pc, buf_instr, 1'b1};
      else if (ld_mis) {if_id_pc, if_id_instr, if_id_valid} <= {pc_i, NOP_INSTR, 1'b1};
    end
  end
`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) if_id_misalign <= 1'b0;
    else if (if_flush || ld_rsp || ld_hold || ld_mis) if_id_misalign <= ld_mis;
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + random closed-loop bench with PC generator, memory model and load scoreboard
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [31:0] pc, redirect = '0, reset_pc = '0, paddr = '0;
  logic [31:0] if_id_pc, if_id_instr;
  logic if_id_valid, fetch_busy;
  int passed = 0, total = 0, mem_lat = 1, cnt = 0;
  exp_t q[$];
  if_fetch_unit_if #(.XLEN(32)) imem();
`ifdef IF_MISALIGN_TRAP_EN
  logic if_id_misalign;
`endif
  if_fetch_unit #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_i(pc), .if_stall(stall), .if_flush(flush), .imem(imem),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
`ifdef IF_MISALIGN_TRAP_EN
    .if_id_misalign(if_id_misalign),
`endif
    .fetch_busy(fetch_busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 0 ? 32'h00500093 : (a * 32'h9E3779B1) ^ 32'h13;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  // memory: one response per accepted request, mem_lat edges after the handshake
  always @(posedge clk) begin
    imem.rsp_valid <= 1'b0;
    if (imem.req_valid && imem.req_ready) begin
      check("one_outstanding", cnt, 0);
      if (mem_lat == 1) begin
        imem.rsp_valid <= 1'b1;
        imem.rsp_data  <= mem_word(imem.req_addr);
      end else begin
        cnt   <= mem_lat - 1;
        paddr <= imem.req_addr;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        imem.rsp_valid <= 1'b1;
        imem.rsp_data  <= mem_word(paddr);
      end
    end
  end
  // PC generator: the PC it holds when it advances must be the instruction IF/ID loads at that edge
  always @(posedge clk) begin
    if (reset) begin
      pc <= reset_pc;
      q.delete();
    end else if (!fetch_busy) begin
      if (flush) pc <= redirect;
      else begin
        q.push_back('{pc, mem_word({pc[31:2], 2'b00})});
        pc <= pc + 4;
      end
    end
  end
  initial begin
    logic [31:0] ppc, pinstr;
    logic pv;
    exp_t e;
    ppc = '0; pinstr = NOP; pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("rst_valid", if_id_valid, 0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc", if_id_pc, 0);
        check("rst_req", imem.req_valid, 0);
        ppc = '0; pinstr = NOP; pv = 1'b0;
      end else begin
        if (flush) begin
          check("flush_valid", if_id_valid, 0);
          check("flush_instr", if_id_instr, NOP);
          check("flush_busy", fetch_busy, 0);
          check("flush_noreq", imem.req_valid, 0);
        end else if (stall) begin
          check("stall_hold_pc", if_id_pc, ppc);
          check("stall_hold_instr", if_id_instr, pinstr);
          check("stall_hold_valid", if_id_valid, pv);
        end else if (if_id_valid && (!pv || if_id_pc != ppc || if_id_instr != pinstr)) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_load: got pc %h instr %h, expected no load", if_id_pc, if_id_instr);
          end else begin
            e = q.pop_front();
            check("load_pc", if_id_pc, e.pc);
            check("load_instr", if_id_instr, e.instr);
          end
        end
        if (imem.req_valid) check("req_addr", imem.req_addr, pc & 32'hFFFFFFFC);
        ppc = if_id_pc; pinstr = if_id_instr; pv = if_id_valid;
      end
    end
  end
  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imem.req_valid && imem.req_addr == a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_req_found", n < 50, 1);
  endtask
  initial begin
    imem.req_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("c1_req_valid", imem.req_valid, 1);
    check("c1_req_addr", imem.req_addr, 0);
    check("c1_if_id_valid", if_id_valid, 0);
    @(negedge clk);
    check("c2_busy_low", fetch_busy, 0);
    @(negedge clk);
    check("c3_busy_high", fetch_busy, 1);
    check("c3_req_addr", imem.req_addr, 4);
    check("c3_if_id_instr", if_id_instr, 32'h00500093);
    check("c3_if_id_valid", if_id_valid, 1);
    wait_req(8);
    imem.req_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("nrdy_req_valid", imem.req_valid, 1);
      check("nrdy_req_addr", imem.req_addr, 8);
      check("nrdy_busy", fetch_busy, 1);
      check("nrdy_if_id_pc", if_id_pc, 4);
    end
    imem.req_ready = 1'b1;
    wait_req(32'hC);
    stall = 1'b1;
    @(negedge clk);
    check("stall1_if_id_pc", if_id_pc, 8);
    @(negedge clk);
    check("stall2_if_id_pc", if_id_pc, 8);
    check("hold_busy", fetch_busy, 1);
    check("hold_noreq", imem.req_valid, 0);
    stall = 1'b0;
    #1;
    check("hold_release_busy", fetch_busy, 0);
    @(negedge clk);
    check("hold_load_pc", if_id_pc, 32'hC);
    check("hold_load_instr", if_id_instr, mem_word(32'hC));
    mem_lat = 3;
    wait_req(32'h10);
    @(negedge clk);
    flush = 1'b1;
    redirect = 32'h100;
    @(negedge clk);
    flush = 1'b0;
    check("drop_if_id_valid", if_id_valid, 0);
    check("drop_if_id_instr", if_id_instr, NOP);
    check("drop_noreq", imem.req_valid, 0);
    wait_req(32'h100);
    check("redirect_addr", imem.req_addr, 32'h100);
    @(negedge clk);
    reset_pc = 32'h200;
    reset = 1'b1;
    #1;
    check("async_rst_valid", if_id_valid, 0);
    check("async_rst_instr", if_id_instr, NOP);
    check("async_rst_pc", if_id_pc, 0);
    check("async_rst_req", imem.req_valid, 0);
    check("async_rst_busy", fetch_busy, 1);
    imem.req_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ignored", if_id_valid, 0);
    imem.req_ready = 1'b1;
    mem_lat = 1;
    wait_req(32'h200);
    repeat (3000) begin
      @(negedge clk);
      stall = $urandom_range(0, 9) < 3;
      flush = $urandom_range(0, 19) == 0;
      redirect = $urandom_range(0, 1023) << 2;
      imem.req_ready = $urandom_range(0, 9) < 7;
      mem_lat = $urandom_range(1, 4);
    end
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    imem.req_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
